// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 interrupt entry sequencer.
// Holds the sequencer state enum, PSR field positions and vector table base.
package lc3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWAP_SP,
        ST_PUSH_PSR,
        ST_PUSH_PC,
        ST_READ_VEC,
        ST_COMMIT
    } int_state_e;

    localparam logic [7:0] VEC_TABLE_HI = 8'h01;
    localparam int PSR_PRIV_BIT = 15;
    localparam int PSR_PRIO_MSB = 10;
    localparam int PSR_PRIO_LSB = 8;

    function automatic logic [15:0] vec_addr(input logic [7:0] v);
        return {VEC_TABLE_HI, v};
    endfunction

endpackage

// File: rtl/lc3_mem_req.sv
// Single memory access engine: holds a request until mem_r_i, then pulses done_o.
// Ports: start_i/we_i/addr_i/wdata_i issue; mem_* drive the bus; done_o/rdata_o report.
module lc3_mem_req
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic        mem_r_i,
    input  logic [15:0] mem_rdata_i,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic        done_o,
    output logic [15:0] rdata_o
);

    logic        en_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        done_q;
    logic [15:0] rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= en_q & mem_r_i;
            if (start_i) begin
                en_q    <= 1'b1;
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end else if (en_q && mem_r_i) begin
                // Address/data stay put; only the request qualifiers drop.
                en_q    <= 1'b0;
                we_q    <= 1'b0;
                rdata_q <= mem_rdata_i;
            end
        end
    end

    assign mem_en_o    = en_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;

endmodule

// File: rtl/lc3_int_sequencer.sv
// LC-3 interrupt entry: stack swap, push PSR/PC, vector fetch, commit new PC/PSR/R6.
// Inputs: request, CPU state, memory ready/data. Outputs: registered memory bus and strobes.
module lc3_int_sequencer
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  INT_Priority,
    input  logic [7:0]  INTV,
    input  logic        INSN_BOUNDARY,
    input  logic [15:0] PSR_IN,
    input  logic [15:0] PC_IN,
    input  logic [15:0] R6_IN,
    input  logic [15:0] SAVED_SSP,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_R,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic        BUSY,
    output logic        USP_WE,
    output logic        R6_WE,
    output logic [15:0] R6_WDATA,
    output logic        PSR_WE,
    output logic [15:0] PSR_OUT,
    output logic        PC_LOAD,
    output logic [15:0] PC_OUT,
    output logic        INT_ACK
);

    int_state_e  state_q, state_d;
    logic        sent_q, sent_d;
    logic [7:0]  intv_q;
    logic [2:0]  prio_q;
    logic [15:0] psr_q;
    logic [15:0] pc_q;
    logic [15:0] sp_q;

    logic        busy_q;
    logic        usp_we_q;
    logic        commit_q;
    logic [15:0] pc_out_q;
    logic [15:0] psr_out_q;
    logic [15:0] r6_wdata_q;

    logic        accept;
    logic        start;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        done;
    logic [15:0] vec_data;
    logic [15:0] sp_m1;
    logic [15:0] sp_m2;

    assign sp_m1 = sp_q - 16'd1;
    assign sp_m2 = sp_q - 16'd2;

    assign accept = (state_q == ST_IDLE) && INSN_BOUNDARY &&
                    (INT_Priority > PSR_IN[PSR_PRIO_MSB:PSR_PRIO_LSB]);

    always_comb begin
        state_d   = state_q;
        sent_d    = sent_q;
        start     = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sent_d  = 1'b0;
                    state_d = PSR_IN[PSR_PRIV_BIT] ? ST_SWAP_SP : ST_PUSH_PSR;
                end
            end
            ST_SWAP_SP: begin
                state_d = ST_PUSH_PSR;
            end
            ST_PUSH_PSR: begin
                // First cycle only launches the push once SP is settled.
                if (!sent_q) begin
                    sent_d    = 1'b1;
                    start     = 1'b1;
                    req_we    = 1'b1;
                    req_addr  = sp_m1;
                    req_wdata = psr_q;
                end else if (done) begin
                    state_d   = ST_PUSH_PC;
                    start     = 1'b1;
                    req_we    = 1'b1;
                    req_addr  = sp_m2;
                    req_wdata = pc_q;
                end
            end
            ST_PUSH_PC: begin
                if (done) begin
                    state_d  = ST_READ_VEC;
                    start    = 1'b1;
                    req_addr = vec_addr(intv_q);
                end
            end
            ST_READ_VEC: begin
                if (done) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sent_q     <= 1'b0;
            intv_q     <= '0;
            prio_q     <= '0;
            psr_q      <= '0;
            pc_q       <= '0;
            sp_q       <= '0;
            busy_q     <= 1'b0;
            usp_we_q   <= 1'b0;
            commit_q   <= 1'b0;
            pc_out_q   <= '0;
            psr_out_q  <= '0;
            r6_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            if (accept) begin
                intv_q <= INTV;
                prio_q <= INT_Priority;
                psr_q  <= PSR_IN;
                pc_q   <= PC_IN;
            end
            if (accept && !PSR_IN[PSR_PRIV_BIT]) begin
                sp_q <= R6_IN;
            end else if (state_q == ST_SWAP_SP) begin
                sp_q <= SAVED_SSP;
            end
            busy_q   <= (state_d != ST_IDLE);
            usp_we_q <= (state_d == ST_SWAP_SP);
            commit_q <= (state_d == ST_COMMIT);
            if (state_d == ST_COMMIT) begin
                pc_out_q   <= vec_data;
                psr_out_q  <= {1'b0, psr_q[14:11], prio_q, psr_q[7:0]};
                r6_wdata_q <= sp_m2;
            end
        end
    end

    lc3_mem_req u_mem (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .we_i        (req_we),
        .addr_i      (req_addr),
        .wdata_i     (req_wdata),
        .mem_r_i     (MEM_R),
        .mem_rdata_i (MEM_RDATA),
        .mem_en_o    (MEM_EN),
        .mem_we_o    (MEM_WE),
        .mem_addr_o  (MEM_ADDR),
        .mem_wdata_o (MEM_WDATA),
        .done_o      (done),
        .rdata_o     (vec_data)
    );

    assign BUSY     = busy_q;
    assign USP_WE   = usp_we_q;
    assign R6_WE    = commit_q;
    assign R6_WDATA = r6_wdata_q;
    assign PSR_WE   = commit_q;
    assign PSR_OUT  = psr_out_q;
    assign PC_LOAD  = commit_q;
    assign PC_OUT   = pc_out_q;
    assign INT_ACK  = commit_q;

endmodule

// File: tb/tb_lc3_int_sequencer.sv
// Scoreboard bench for lc3_int_sequencer: directed scenarios plus random requests.
// A memory responder with programmable wait states feeds a write/read log to the monitor.
module tb_lc3_int_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  INT_Priority;
    logic [7:0]  INTV;
    logic        INSN_BOUNDARY;
    logic [15:0] PSR_IN, PC_IN, R6_IN, SAVED_SSP;
    logic [15:0] MEM_RDATA;
    logic        MEM_R;
    logic        MEM_EN, MEM_WE;
    logic [15:0] MEM_ADDR, MEM_WDATA;
    logic        BUSY, USP_WE, R6_WE, PSR_WE, PC_LOAD, INT_ACK;
    logic [15:0] R6_WDATA, PSR_OUT, PC_OUT;

    typedef struct {
        logic [15:0] w0a, w0d, w1a, w1d, ra, pc, psr, r6;
        int usp;
        int lat;
        int start;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wr_log[$];
    logic [15:0] rd_log[$];
    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int delay_cfg = 0;
    int usp_cnt = 0;
    int wait_cnt = 0;
    bit busy_seen, en_seen, pcl_seen;
    logic [15:0] hold_a, hold_d;
    bit stable;
    logic any_out;

    assign any_out = |{MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, BUSY, USP_WE,
                       R6_WE, R6_WDATA, PSR_WE, PSR_OUT, PC_LOAD, PC_OUT, INT_ACK};

    lc3_int_sequencer dut (
        .clk(clk), .reset(reset),
        .INT_Priority(INT_Priority), .INTV(INTV), .INSN_BOUNDARY(INSN_BOUNDARY),
        .PSR_IN(PSR_IN), .PC_IN(PC_IN), .R6_IN(R6_IN), .SAVED_SSP(SAVED_SSP),
        .MEM_RDATA(MEM_RDATA), .MEM_R(MEM_R),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .BUSY(BUSY), .USP_WE(USP_WE), .R6_WE(R6_WE), .R6_WDATA(R6_WDATA),
        .PSR_WE(PSR_WE), .PSR_OUT(PSR_OUT), .PC_LOAD(PC_LOAD), .PC_OUT(PC_OUT),
        .INT_ACK(INT_ACK)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory responder: answers after delay_cfg wait cycles, checks bus stability.
    always @(negedge clk) begin
        if (reset) begin
            MEM_R = 1'b0;
            wait_cnt = 0;
        end else if (MEM_EN && !MEM_R) begin
            if (wait_cnt == 0) begin
                hold_a = MEM_ADDR;
                hold_d = MEM_WDATA;
                stable = 1'b1;
            end else if (MEM_ADDR !== hold_a || MEM_WDATA !== hold_d) begin
                stable = 1'b0;
            end
            if (wait_cnt >= delay_cfg) begin
                chk("mem_bus_stable", stable, 1);
                MEM_R = 1'b1;
                MEM_RDATA = mem[MEM_ADDR];
                if (MEM_WE) begin
                    mem[MEM_ADDR] = MEM_WDATA;
                    wr_log.push_back({MEM_ADDR, MEM_WDATA});
                end else begin
                    rd_log.push_back(MEM_ADDR);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            MEM_R = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT commits.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (USP_WE) usp_cnt++;
            if (BUSY) busy_seen = 1'b1;
            if (MEM_EN) en_seen = 1'b1;
            if (PC_LOAD) pcl_seen = 1'b1;
            if (INT_ACK) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", INT_ACK, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_out", PC_OUT, e.pc);
                    chk("psr_out", PSR_OUT, e.psr);
                    chk("r6_wdata", R6_WDATA, e.r6);
                    chk("strobes", {PC_LOAD, PSR_WE, R6_WE, BUSY}, 4'hF);
                    chk("latency", cyc - e.start, e.lat);
                    chk("usp_we_pulses", usp_cnt, e.usp);
                    chk("write_count", wr_log.size(), 2);
                    if (wr_log.size() == 2) begin
                        chk("push_psr", wr_log[0], {e.w0a, e.w0d});
                        chk("push_pc", wr_log[1], {e.w1a, e.w1d});
                    end
                    chk("read_count", rd_log.size(), 1);
                    if (rd_log.size() == 1) chk("vec_addr", rd_log[0], e.ra);
                end
                wr_log.delete();
                rd_log.delete();
                usp_cnt = 0;
            end
        end
    end

    // Issue one request; mode 1 scrambles latched inputs, mode 2 moves INTV in PUSH_PC.
    task automatic fire(input logic [15:0] psr, input logic [15:0] pc,
                        input logic [15:0] r6, input logic [15:0] ssp,
                        input logic [2:0] prio, input logic [7:0] intv,
                        input logic [15:0] vec, input int dly, input int mode);
        exp_t e;
        logic [15:0] sp;
        bit acc;
        bit done;
        delay_cfg = dly;
        mem[{8'h01, intv}] = vec;
        busy_seen = 1'b0;
        en_seen = 1'b0;
        @(negedge clk);
        PSR_IN = psr; PC_IN = pc; R6_IN = r6; SAVED_SSP = ssp;
        INT_Priority = prio; INTV = intv; INSN_BOUNDARY = 1'b1;
        acc = prio > psr[10:8];
        sp = psr[15] ? ssp : r6;
        @(negedge clk);
        INSN_BOUNDARY = 1'b0;
        if (!acc) begin
            repeat (12) @(negedge clk);
            chk("reject_busy", busy_seen, 0);
            chk("reject_mem_en", en_seen, 0);
            return;
        end
        e.start = cyc;
        e.w0a = sp - 16'd1; e.w0d = psr;
        e.w1a = sp - 16'd2; e.w1d = pc;
        e.ra = {8'h01, intv};
        e.pc = vec;
        e.psr = {1'b0, psr[14:11], prio, psr[7:0]};
        e.r6 = sp - 16'd2;
        e.usp = psr[15] ? 1 : 0;
        e.lat = 7 + (psr[15] ? 1 : 0) + 3 * dly;
        exp_q.push_back(e);
        if (mode == 1) begin
            PSR_IN = 16'($urandom); PC_IN = 16'($urandom);
            INT_Priority = 3'($urandom); INTV = 8'($urandom);
        end
        if (mode == 2) begin
            for (int i = 0; i < 40; i++) begin
                if (MEM_EN && MEM_WE && MEM_ADDR == e.w1a) break;
                @(negedge clk);
            end
            INTV = 8'h81;
        end
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
        end
        chk("commit_timeout", done, 1);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin : stim
        bit found;
        reset = 1'b1;
        INT_Priority = '0; INTV = '0; INSN_BOUNDARY = 1'b0;
        PSR_IN = '0; PC_IN = '0; R6_IN = '0; SAVED_SSP = '0;
        MEM_RDATA = '0; MEM_R = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", any_out, 0);
        reset = 1'b0;
        @(negedge clk);

        // User-mode entry with stack swap.
        fire(16'h8002, 16'h3005, 16'hF000, 16'h3000, 3'd1, 8'h80, 16'h1000, 0, 0);
        chk("mem_2fff", mem[16'h2FFF], 16'h8002);
        chk("mem_2ffe", mem[16'h2FFE], 16'h3005);

        // Supervisor-mode entry, no swap.
        fire(16'h0000, 16'h4000, 16'h2FF0, 16'h3000, 3'd1, 8'h22, 16'h0400, 0, 0);
        chk("mem_2fef", mem[16'h2FEF], 16'h0000);
        chk("mem_2fee", mem[16'h2FEE], 16'h4000);

        // Equal priority is rejected.
        fire(16'h0300, 16'h4000, 16'h2FF0, 16'h3000, 3'd3, 8'h22, 16'h0400, 0, 0);

        // Three wait states per access.
        fire(16'h0000, 16'h5000, 16'h2FF0, 16'h3000, 3'd2, 8'h33, 16'h0500, 3, 0);

        // INTV moves during PUSH_PC; vector still from 0x0180.
        mem[16'h0181] = 16'hDEAD;
        fire(16'h0001, 16'h6000, 16'h2000, 16'h3000, 3'd2, 8'h80, 16'h2222, 0, 2);

        // Reset while reading the vector.
        delay_cfg = 3;
        mem[16'h0140] = 16'h5555;
        @(negedge clk);
        PSR_IN = 16'h0000; PC_IN = 16'h1234; R6_IN = 16'h4000;
        INT_Priority = 3'd4; INTV = 8'h40; INSN_BOUNDARY = 1'b1;
        @(negedge clk);
        INSN_BOUNDARY = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            found = MEM_EN && !MEM_WE;
        end
        chk("reached_read_vec", found, 1);
        chk("read_vec_addr", MEM_ADDR, 16'h0140);
        chk("writes_before_reset", wr_log.size(), 2);
        #2 reset = 1'b1;
        #1 chk("outputs_in_reset", any_out, 0);
        @(negedge clk);
        reset = 1'b0;
        pcl_seen = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_pc_load_after_reset", pcl_seen, 0);
        wr_log.delete();
        rd_log.delete();
        usp_cnt = 0;

        // Random requests against the model.
        for (int n = 0; n < 24; n++) begin
            fire(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 3'($urandom), 8'($urandom), 16'($urandom),
                 int'($urandom_range(0, 2)), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3_int_sequencer.md
LC3_INT_SEQUENCER -- requirements
Module: lc3_int_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk` (input, 1) is the sole clock and `reset` (input, 1) is the asynchronous, active-high reset.
REQ-002 INT_Priority  input  3  priority of the pending interrupt request; 0 means no request.
REQ-003 INTV  input  8  vector number of the pending request.
REQ-004 INSN_BOUNDARY  input  1  one-cycle pulse from the CPU control unit when the current instruction has completed.
REQ-005 PSR_IN  input  16  current PSR: bit15 PRIV (1=user), bits10:8 PRIORITY, bits2:0 NZP.
REQ-006 PC_IN  input  16  address of the next instruction.
REQ-007 R6_IN  input  16  current stack pointer.
REQ-008 SAVED_SSP  input  16  saved supervisor stack pointer.
REQ-009 MEM_RDATA  input  16  memory read data, valid when MEM_R=1.
REQ-010 MEM_R  input  1  memory ready; completes the current access.
REQ-011 MEM_EN, MEM_WE  output  1 each  memory access request and write qualifier.
REQ-012 MEM_ADDR, MEM_WDATA  output  16 each  memory address and write data.
REQ-013 BUSY  output  1  CPU fetch stalled; interrupt entry in progress.
REQ-014 USP_WE  output  1  strobe that saves R6_IN into the Saved_USP register.
REQ-015 R6_WE, R6_WDATA  output  1/16  writeback of the final supervisor stack pointer.
REQ-016 PSR_WE, PSR_OUT  output  1/16  new PSR.
REQ-017 PC_LOAD, PC_OUT  output  1/16  new PC.
REQ-018 INT_ACK  output  1  one-cycle acknowledge to the interrupt source.

Function
REQ-019 The block SHALL accept an interrupt in IDLE only when INSN_BOUNDARY=1 and INT_Priority > PSR_IN[10:8], using an unsigned comparison; equal priority SHALL NOT be accepted.
REQ-020 On acceptance, the block SHALL latch INTV, INT_Priority, PSR_IN and PC_IN, and later changes on these inputs SHALL be ignored until the sequence returns to IDLE.
REQ-021 The states SHALL be IDLE, SWAP_SP, PUSH_PSR, PUSH_PC, READ_VEC, COMMIT.
- IDLE to SWAP_SP: on acceptance with PRIV=1.
- IDLE to PUSH_PSR: on acceptance with PRIV=0.
REQ-022 In SWAP_SP, the block SHALL pulse USP_WE for one cycle, load the internal SP with SAVED_SSP, and advance to PUSH_PSR; with PRIV=0, the internal SP SHALL instead load R6_IN at acceptance.
REQ-023 PUSH_PSR SHALL write the latched PSR to address SP-1.
REQ-024 PUSH_PC SHALL write the latched PC to address SP-2, with all SP arithmetic modulo 2^16.
REQ-025 READ_VEC SHALL read address {8'h01, INTV}, and SHALL capture MEM_RDATA on the MEM_R cycle.
REQ-026 In each memory state, MEM_EN SHALL be held with stable address/data until the cycle MEM_R=1; the state SHALL advance on the cycle after that, with MEM_EN low for one cycle between accesses.
REQ-027 COMMIT SHALL last one cycle and pulse all of the following before returning to IDLE:
- PC_LOAD with PC_OUT = vector data;
- PSR_WE with PSR_OUT = {1'b0, latched[14:11], latched priority, latched[7:0]};
- R6_WE with R6_WDATA = SP-2;
- INT_ACK.
REQ-028 BUSY SHALL be 1 in every state except IDLE.
REQ-029 Outputs SHALL be registered, and MEM_WE SHALL be 1 only in PUSH_PSR and PUSH_PC.
REQ-030 With MEM_R tied to 1, latency SHALL be as follows:
- PRIV=0: 7 cycles from the acceptance edge to the COMMIT cycle.
- PRIV=1: 8 cycles.
REQ-031 A new acceptance SHALL NOT occur in the COMMIT cycle; the earliest is the next INSN_BOUNDARY in IDLE.

Reset
REQ-032 While reset=1, the block SHALL force IDLE, all outputs to 0, and all latched registers to 0, asynchronously.
REQ-033 A reset asserted mid-sequence SHALL abandon the sequence with no further strobes; writes already completed SHALL NOT be undone.

Structure
REQ-034 A shared package lc3_pkg SHALL hold the following:
- the state enum;
- the constants VEC_TABLE_HI=8'h01, PSR_PRIV_BIT=15, PSR_PRIO_MSB=10, PSR_PRIO_LSB=8.
REQ-035 One sub-module, lc3_mem_req, SHALL be used; it holds MEM_EN until MEM_R and reports done for one cycle.

Verification
REQ-036 The bench SHALL cover the following scenario: user mode, PSR_IN=16'h8002, PC=16'h3005, R6=16'hF000, SAVED_SSP=16'h3000, INT_Priority=1, INTV=8'h80, mem[16'h0180]=16'h1000. Required response:
- USP_WE pulse;
- mem[16'h2FFF]=16'h8002 and mem[16'h2FFE]=16'h3005;
- PC_OUT=16'h1000, PSR_OUT=16'h0102, R6_WDATA=16'h2FFE;
- INT_ACK pulses once.
REQ-037 The bench SHALL cover the following scenario: supervisor mode, PSR_IN=16'h0000, R6=16'h2FF0, priority 1 -> no USP_WE, writes at 16'h2FEF and 16'h2FEE, R6_WDATA=16'h2FEE.
REQ-038 The bench SHALL cover the following scenario: PSR priority 3, INT_Priority=3 with INSN_BOUNDARY pulsed -> BUSY stays 0 and no MEM_EN.
REQ-039 The bench SHALL cover the following scenario: MEM_R delayed 3 cycles on each access -> MEM_ADDR and MEM_WDATA stable throughout, and completion after 7 + 3*3 cycles (supervisor mode).
REQ-040 The bench SHALL cover the following scenario: INTV changes to 8'h81 during PUSH_PC -> vector read still at 16'h0180.
REQ-041 The bench SHALL cover the following scenario: reset asserted in READ_VEC -> same-cycle return to IDLE, all outputs 0, and no PC_LOAD.
